// File: rtl/param_shift_reg_if.sv
// rtl/param_shift_reg_if.sv - Control, data and status bundle for param_shift_reg
interface param_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(WIDTH + 1);

  logic             Start;
  logic [2:0]       Mode;
  logic [AW-1:0]    Amount;
  logic [WIDTH-1:0] D;
  logic             Sin;
  logic [WIDTH-1:0] Q;
  logic             SOut;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Mode, Amount, D, Sin,
    input  Q, SOut, Busy, Done
  );

  modport slave (
    input  Start, Mode, Amount, D, Sin,
    output Q, SOut, Busy, Done
  );
endinterface

// File: rtl/param_shift_reg.sv
// rtl/param_shift_reg.sv - Universal shift register, bit-serial by default
// SHIFT_REG_BARREL_EN: all shifts finish on the Start edge through a barrel network
module param_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  param_shift_reg_if.slave bus
);
  localparam int AW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    amt_sat;
  logic             is_shift;

`ifndef SHIFT_REG_BARREL_EN
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [AW-1:0] cnt_q, cnt_d;
`else
  logic [WIDTH:0] acc;
`endif

  // One shift step; returns {bit_out, next_q}. Non-shift modes keep SOut as is.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] q, input logic [2:0] mode,
                                          input logic sin, input logic sout);
    case (mode)
      MODE_SHL:  step = {q[WIDTH-1], q[WIDTH-2:0], sin};
      MODE_SHR:  step = {q[0], sin, q[WIDTH-1:1]};
      MODE_ROTL: step = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: step = {q[0], q[0], q[WIDTH-1:1]};
      MODE_ASR:  step = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
      default:   step = {sout, q};
    endcase
  endfunction

  assign amt_sat  = (bus.Amount > AW'(WIDTH)) ? AW'(WIDTH) : bus.Amount;
  assign is_shift = (bus.Mode != MODE_HOLD) && (bus.Mode != MODE_LOAD) &&
                    (bus.Mode != MODE_CLEAR);

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    busy_d = busy_q;
    done_d = 1'b0;
`ifndef SHIFT_REG_BARREL_EN
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (!is_shift) begin
            done_d = 1'b1;
            if (bus.Mode == MODE_LOAD) q_d = bus.D;
            else if (bus.Mode == MODE_CLEAR) q_d = '0;
          end else if (amt_sat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            mode_d  = bus.Mode;
            cnt_d   = amt_sat;
          end
        end
      end
      RUN: begin
        {sout_d, q_d} = step(q_q, mode_q, bus.Sin, sout_q);
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    acc = {sout_q, q_q};
    if (bus.Start) begin
      done_d = 1'b1;
      if (bus.Mode == MODE_LOAD) begin
        q_d = bus.D;
      end else if (bus.Mode == MODE_CLEAR) begin
        q_d = '0;
      end else if (is_shift) begin
        // Unrolled chain of single steps; Sin stays constant so it fills every vacated bit
        for (int i = 0; i < WIDTH; i++) begin
          if (i < int'(amt_sat)) acc = step(acc[WIDTH-1:0], bus.Mode, bus.Sin, acc[WIDTH]);
        end
        {sout_d, q_d} = acc;
      end
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef SHIFT_REG_BARREL_EN
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
`endif
    end else begin
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifndef SHIFT_REG_BARREL_EN
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.Q    = q_q;
  assign bus.SOut = sout_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
Parametrised universal shift register, the successor to the team's fixed 8-bit D-register bank. Supports hold, parallel load, clear, logical shifts, rotates and arithmetic shift right. Multi-bit shifts run one bit per cycle under a Start/Busy/Done handshake. Used as a datapath staging register and a serialiser/deserialiser in lab datapaths.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AW, $clog2(WIDTH+1), width of the Amount port (derived; not overridden)

Ports:
Clock  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
Start  input  1  operation request, sampled only in IDLE
Mode  input  3  operation select, sampled with Start
Amount  input  AW  shift/rotate count, sampled with Start
D  input  WIDTH  parallel load data, sampled with Start
Sin  input  1  serial input bit, sampled on every shift step
Q  output  WIDTH  register contents
SOut  output  1  last bit shifted or rotated out (registered)
Busy  output  1  high while a multi-cycle shift is in progress
Done  output  1  one-cycle pulse when an operation completes

Behaviour:
- Reset is synchronous and active-high on Clock. Reset values: Q=0, SOut=0, Busy=0, Done=0, FSM state=IDLE, internal count=0. Reset overrides everything, including mid-operation.
- Mode encoding:
  - 000 HOLD
  - 001 LOAD (Q<=D)
  - 010 SHL (Q<={Q[W-2:0],Sin})
  - 011 SHR (Q<={Sin,Q[W-1:1]})
  - 100 ROTL
  - 101 ROTR
  - 110 ASR (Q<={Q[W-1],Q[W-1:1]}; Sin ignored)
  - 111 CLEAR (Q<=0)
- FSM states: IDLE and RUN.
- IDLE behaviour:
  - Start=0: Q holds and Done=0.
  - Start=1 with HOLD, LOAD or CLEAR: the operation is applied on that edge. Done=1 for the next cycle. State stays IDLE.
  - Start=1 with a shift mode (010-110) and Amount=0: Q is unchanged, Done=1 for the next cycle, Busy never asserts.
  - Start=1 with a shift mode and Amount>0: latch Mode and count=min(Amount,WIDTH). Amount>WIDTH saturates to WIDTH. Go to RUN. Q is not changed on the Start edge.
- RUN behaviour:
  - Busy=1 for the whole state.
  - Each edge performs one step of the latched mode and decrements count.
  - SOut captures the bit leaving Q on each step: Q[W-1] for SHL/ROTL, Q[0] for SHR/ROTR/ASR.
  - On the edge that performs the step with count==1, the state goes to IDLE and Done=1 for the following cycle.
  - Latency: N steps means Q changes on edges 1..N after the Start edge, Busy is high for N cycles, and Done is high in cycle N+1.
- Start is ignored while in RUN. Mode, Amount and D are don't-care outside the Start edge.
- Done is asserted only for the single cycle after a completion. Back-to-back: Start may be asserted in the same cycle Done is high (state is IDLE).
- LOAD, CLEAR and HOLD leave SOut unchanged.
- Reset asserted during RUN: at the next edge Q=0, Busy=0, Done=0, state=IDLE. The aborted operation produces no Done pulse.

Optional Feature:
- Macro: SHIFT_REG_BARREL_EN.
- Defined: all shift modes complete on the Start edge in a single cycle via a barrel shifter, shifting by min(Amount,WIDTH). Sin, sampled on the Start edge, fills all vacated positions for SHL/SHR. SOut is the last bit shifted out. Busy stays 0. Done=1 in the next cycle. RUN state is not synthesised.
- Undefined: the bit-serial RUN behaviour above.

Test Plan:
1. Reset held for 2 cycles, then released -> Q=8'h00, SOut=0, Busy=0, Done=0; idle cycles keep Q=8'h00.
2. LOAD: Start, Mode=001, D=8'hA5 -> Q=8'hA5 after the Start edge; Done=1 for exactly one cycle; Busy stays 0.
3. SHL: from Q=8'hA5, Start, Mode=010, Amount=3, Sin=1 -> Q sequence 8'h4B, 8'h97, 8'h2F. Busy high 3 cycles, then Done pulse. SOut=1.
4. ASR: from Q=8'h90, Mode=110, Amount=2 -> Q=8'hC8 then 8'hE4; SOut=0. ROTR from Q=8'h81, Amount=12 -> saturates to 8 steps, final Q=8'h81, Busy high 8 cycles.
5. Start pulsed mid-RUN with Mode=111 -> ignored, shift completes normally. Reset asserted on the 2nd step of a 5-step SHL -> next edge Q=0, Busy=0, no Done pulse.
6. SHL with Amount=0 -> Q unchanged, Busy never high, Done pulse one cycle after Start. With SHIFT_REG_BARREL_EN defined, scenario 3 gives Q=8'h2F one edge after Start, Busy=0.
